// File: rtl/uart_wb_arb_pkg.sv
// Shared definitions for the two-master UART Wishbone arbiter: state encoding,
// default watchdog limit and the round-robin pick used when leaving IDLE.
package uart_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

    // One-hot {m1, m0} grant for the requesters; a tie goes to the master not served last.
    function automatic logic [1:0] rr_pick(input logic req0, input logic req1, input logic last);
        logic [1:0] pick;
        if (req0 && req1) begin
            pick = last ? 2'b01 : 2'b10;
        end else begin
            pick = {req1, req0};
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_wb_arb_wdog.sv
// Stall watchdog: counts cycles a granted strobe waits for ack and raises a
// one-cycle expire pulse when the count reaches TIMEOUT-1.
module uart_wb_arb_wdog
    import uart_wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)(
    input  logic clk,
    input  logic wb_rst_i,
    input  logic run_i,
    output logic expire_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 32'd1);

    logic [7:0] cnt_d;
    logic [7:0] cnt_q;

    // Next count: advance while stalled, restart on ack, release or expiry.
    always_comb begin
        expire_o = run_i && (cnt_q == LIMIT);
        if (run_i && !expire_o) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd0;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_wb_arb.sv
// Round-robin, cycle-locked arbiter letting two Wishbone masters share the UART
// register slave. Define UART_WB_ARB_TIMEOUT_EN to build the stall watchdog
// (the TIMEOUT parameter exists only in that build).
module uart_wb_arb
    import uart_wb_arb_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 32
`ifdef UART_WB_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
`endif
)(
    input  logic            clk,
    input  logic            wb_rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [DW-1:0]   m_dat_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    output logic [1:0]      gnt_o
);

    arb_state_e state_d;
    arb_state_e state_q;
    logic       last_d;
    logic       last_q;
    logic [1:0] gnt_d;
    logic [1:0] gnt_q;
    logic       own_cyc_s;
    logic       expire_s;

`ifdef UART_WB_ARB_TIMEOUT_EN
    logic       run_s;
    logic [1:0] err_d;
    logic [1:0] err_q;

    assign run_s = own_cyc_s & s_stb_o & ~s_ack_i;

    uart_wb_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .run_i    (run_s),
        .expire_o (expire_s)
    );

    assign m0_err_o = err_q[0];
    assign m1_err_o = err_q[1];
`else
    assign expire_s = 1'b0;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

    // Slave bus steering: follows the registered grant, so reset clears it at once.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = {AW{1'b0}};
        s_dat_o   = {DW{1'b0}};
        s_sel_o   = {(DW/8){1'b0}};
        own_cyc_s = 1'b0;
        if (gnt_q[0]) begin
            s_cyc_o   = m0_cyc_i;
            s_stb_o   = m0_stb_i;
            s_we_o    = m0_we_i;
            s_adr_o   = m0_adr_i;
            s_dat_o   = m0_dat_i;
            s_sel_o   = m0_sel_i;
            own_cyc_s = m0_cyc_i;
        end else if (gnt_q[1]) begin
            s_cyc_o   = m1_cyc_i;
            s_stb_o   = m1_stb_i;
            s_we_o    = m1_we_i;
            s_adr_o   = m1_adr_i;
            s_dat_o   = m1_dat_i;
            s_sel_o   = m1_sel_i;
            own_cyc_s = m1_cyc_i;
        end else begin
            own_cyc_s = 1'b0;
        end
    end

    assign m0_ack_o = s_ack_i & gnt_q[0];
    assign m1_ack_o = s_ack_i & gnt_q[1];
    assign m_dat_o  = s_dat_i;
    assign gnt_o    = gnt_q;

    // Arbitration next-state: grant from IDLE, hold for the whole cycle, release via IDLE.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
`ifdef UART_WB_ARB_TIMEOUT_EN
        err_d   = 2'b00;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = rr_pick(m0_cyc_i, m1_cyc_i, last_q);
                case (gnt_d)
                    2'b01:   state_d = GNT0;
                    2'b10:   state_d = GNT1;
                    default: state_d = IDLE;
                endcase
            end
            GNT0, GNT1: begin
                if (!own_cyc_s) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    last_d  = (state_q == GNT1);
                end else if (expire_s) begin
                    // The slave never answered: give the bus back and flag the owner.
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    last_d  = (state_q == GNT1);
`ifdef UART_WB_ARB_TIMEOUT_EN
                    err_d   = gnt_q;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // Arbiter state and registered grant/error outputs.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
`ifdef UART_WB_ARB_TIMEOUT_EN
            err_q   <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
`ifdef UART_WB_ARB_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_wb_arb.sv
// Self-checking bench for uart_wb_arb: directed test-plan steps followed by random
// traffic, all compared against a transaction-level ownership model.
module tb_uart_wb_arb;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          wb_rst_i;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [SW-1:0] m0_sel_i;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [SW-1:0] m1_sel_i;
    logic          m1_ack_o, m1_err_o;
    logic [DW-1:0] m_dat_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [SW-1:0] s_sel_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;
    logic [1:0]    gnt_o;

    always #5 clk = ~clk;

    uart_wb_arb dut (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_we_i  (m0_we_i),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_sel_i (m0_sel_i),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_we_i  (m1_we_i),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_sel_i (m1_sel_i),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .m_dat_o  (m_dat_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .gnt_o    (gnt_o)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the bus (-1 nobody), who was served last, stall length.
    int         owner;
    int         last;
    int         wait_cnt;
    logic [1:0] exp_err;

    int         grants, idle_run, err_at, pulses;
    logic [1:0] prev_gnt;
    bit         acked0, acked1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner    = -1;
        last     = 1;
        wait_cnt = 0;
        exp_err  = 2'b00;
    endtask

    // Applies the arbitration rules to the inputs seen at a rising edge.
    task automatic model_edge();
        logic oc;
`ifdef UART_WB_ARB_TIMEOUT_EN
        logic os;
`endif
        exp_err = 2'b00;
        if (wb_rst_i) begin
            model_reset();
        end else if (owner < 0) begin
            if (m0_cyc_i && m1_cyc_i) owner = 1 - last;
            else if (m0_cyc_i)        owner = 0;
            else if (m1_cyc_i)        owner = 1;
            wait_cnt = 0;
        end else begin
            oc = (owner == 0) ? m0_cyc_i : m1_cyc_i;
`ifdef UART_WB_ARB_TIMEOUT_EN
            os = (owner == 0) ? m0_stb_i : m1_stb_i;
`endif
            if (!oc) begin
                last     = owner;
                owner    = -1;
                wait_cnt = 0;
            end
`ifdef UART_WB_ARB_TIMEOUT_EN
            else if (os && !s_ack_i) begin
                wait_cnt++;
                if (wait_cnt == TMO) begin
                    exp_err[owner] = 1'b1;
                    last     = owner;
                    owner    = -1;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    // Compares every output against the model for the inputs currently applied.
    task automatic check_all(input string ph);
        logic          e_cyc, e_stb, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        logic [1:0]    e_gnt;
        #1;
        e_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        if (owner == 0) begin
            e_cyc = m0_cyc_i; e_stb = m0_stb_i; e_we = m0_we_i;
            e_adr = m0_adr_i; e_dat = m0_dat_i; e_sel = m0_sel_i;
        end else if (owner == 1) begin
            e_cyc = m1_cyc_i; e_stb = m1_stb_i; e_we = m1_we_i;
            e_adr = m1_adr_i; e_dat = m1_dat_i; e_sel = m1_sel_i;
        end else begin
            e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
            e_adr = '0;   e_dat = '0;   e_sel = '0;
        end
        chk({ph, "_gnt"},   gnt_o,   e_gnt);
        chk({ph, "_scyc"},  s_cyc_o, e_cyc);
        chk({ph, "_sstb"},  s_stb_o, e_stb);
        chk({ph, "_swe"},   s_we_o,  e_we);
        chk({ph, "_sadr"},  s_adr_o, e_adr);
        chk({ph, "_sdat"},  s_dat_o, e_dat);
        chk({ph, "_ssel"},  s_sel_o, e_sel);
        chk({ph, "_ack0"},  m0_ack_o, s_ack_i && (owner == 0));
        chk({ph, "_ack1"},  m1_ack_o, s_ack_i && (owner == 1));
        chk({ph, "_err0"},  m0_err_o, exp_err[0]);
        chk({ph, "_err1"},  m1_err_o, exp_err[1]);
        chk({ph, "_mdat"},  m_dat_o, s_dat_i);
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        m0_adr_i = '0;   m0_dat_i = '0;   m0_sel_i = '0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        m1_adr_i = '0;   m1_dat_i = '0;   m1_sel_i = '0;
        s_ack_i  = 1'b0; s_dat_i  = '0;
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        idle_inputs();
        model_reset();
        tick();
        wb_rst_i = 1'b0;
        check_all("rst");
    endtask

    initial begin
        // Reset state
        wb_rst_i = 1'b1;
        idle_inputs();
        model_reset();
        check_all("reset");
        tick();
        tick();
        wb_rst_i = 1'b0;
        check_all("post_reset");

        // m0 alone writes LCR-style value
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
        m0_adr_i = 5'h03; m0_dat_i = 32'h0000_0083; m0_sel_i = 4'b0001;
        check_all("m0wr_req");
        chk("m0wr_pre_scyc", s_cyc_o, 64'd0);
        tick();
        s_ack_i = 1'b1;
        check_all("m0wr_gnt");
        chk("m0wr_adr",  s_adr_o,  64'h3);
        chk("m0wr_dat",  s_dat_o,  64'h83);
        chk("m0wr_sel",  s_sel_o,  64'h1);
        chk("m0wr_ack0", m0_ack_o, 64'd1);
        chk("m0wr_ack1", m1_ack_o, 64'd0);
        tick();
        m0_stb_i = 1'b0; s_ack_i = 1'b0;
        check_all("m0wr_hold");
        tick();
        m0_cyc_i = 1'b0;
        check_all("m0wr_drop");
        tick();
        check_all("m0wr_idle");
        chk("m0wr_idle_gnt", gnt_o, 64'd0);

        // Simultaneous request after reset: m0 first, one dead cycle, then m1
        do_reset();
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        check_all("tie_req");
        tick();
        check_all("tie_g0");
        chk("tie_first", gnt_o, 64'd1);
        m0_cyc_i = 1'b0;
        tick();
        check_all("tie_dead");
        chk("tie_dead_gnt", gnt_o, 64'd0);
        tick();
        check_all("tie_g1");
        chk("tie_second", gnt_o, 64'd2);
        idle_inputs();
        tick();
        tick();

        // Both masters keep requesting: grants alternate with one idle cycle between
        do_reset();
        prev_gnt = 2'b00; idle_run = 0; grants = 0; acked0 = 1'b0; acked1 = 1'b0;
        for (int i = 0; i < 40 && grants < 8; i++) begin
            m0_cyc_i = !(owner == 0 && acked0);
            m1_cyc_i = !(owner == 1 && acked1);
            m0_stb_i = m0_cyc_i && (owner == 0) && !acked0;
            m1_stb_i = m1_cyc_i && (owner == 1) && !acked1;
            s_ack_i  = m0_stb_i || m1_stb_i;
            s_dat_i  = $urandom;
            check_all("alt");
            if (gnt_o != 2'b00 && prev_gnt == 2'b00) begin
                chk("alt_order", gnt_o, (grants % 2 == 0) ? 64'd1 : 64'd2);
                if (grants > 0) chk("alt_idle", idle_run, 64'd1);
                grants++;
                idle_run = 0;
            end else if (gnt_o == 2'b00) begin
                idle_run++;
            end
            prev_gnt = gnt_o;
            if (s_ack_i && owner == 0) acked0 = 1'b1;
            if (s_ack_i && owner == 1) acked1 = 1'b1;
            tick();
            if (owner != 0) acked0 = 1'b0;
            if (owner != 1) acked1 = 1'b0;
        end
        chk("alt_count", grants, 64'd8);
        idle_inputs();
        tick();
        tick();

        // m1 holds its cycle for three beats while m0 waits
        do_reset();
        m1_cyc_i = 1'b1;
        check_all("lock_req");
        tick();
        m0_cyc_i = 1'b1;
        for (int b = 0; b < 3; b++) begin
            m1_stb_i = 1'b1; m1_adr_i = 5'(b); s_ack_i = 1'b1;
            check_all("lock_beat");
            chk("lock_gnt",  gnt_o,    64'd2);
            chk("lock_ack0", m0_ack_o, 64'd0);
            tick();
            m1_stb_i = 1'b0; s_ack_i = 1'b0;
            check_all("lock_gap");
            tick();
        end
        m1_cyc_i = 1'b0;
        check_all("lock_drop");
        tick();
        check_all("lock_dead");
        chk("lock_dead_gnt", gnt_o, 64'd0);
        tick();
        check_all("lock_m0");
        chk("lock_m0_gnt", gnt_o, 64'd1);
        idle_inputs();
        tick();
        tick();

        // Slave never acknowledges m0
        do_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 5'h01;
        check_all("stall_req");
        tick();
`ifdef UART_WB_ARB_TIMEOUT_EN
        err_at = -1; pulses = 0;
        for (int i = 0; i < 30; i++) begin
            check_all("stall");
            chk("stall_ack0", m0_ack_o, 64'd0);
            if (m0_err_o === 1'b1) begin
                pulses++;
                if (err_at < 0) err_at = i;
                chk("stall_err_gnt", gnt_o, 64'd0);
                m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
            end
            tick();
        end
        chk("stall_err_at", err_at, 64'd16);
        chk("stall_pulses", pulses, 64'd1);
`else
        for (int i = 0; i < 40; i++) begin
            check_all("stall");
            tick();
        end
        chk("stall_blocked_gnt", gnt_o, 64'd1);
        chk("stall_no_err", m0_err_o, 64'd0);
`endif
        idle_inputs();
        tick();
        tick();

        // Reset in the middle of an m1 transfer
        do_reset();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 5'h05;
        tick();
        check_all("rstmid_g1");
        #2;
        wb_rst_i = 1'b1;
        model_reset();
        #1;
        chk("rstmid_gnt",  gnt_o,   64'd0);
        chk("rstmid_scyc", s_cyc_o, 64'd0);
        chk("rstmid_sstb", s_stb_o, 64'd0);
        tick();
        wb_rst_i = 1'b0;
        m0_cyc_i = 1'b1;
        check_all("rstmid_req");
        tick();
        check_all("rstmid_after");
        chk("rstmid_first", gnt_o, 64'd1);
        idle_inputs();
        tick();
        tick();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(0, 5) == 0) m1_cyc_i = ~m1_cyc_i;
            m0_stb_i = m0_cyc_i & 1'($urandom_range(0, 1));
            m1_stb_i = m1_cyc_i & 1'($urandom_range(0, 1));
            m0_we_i  = 1'($urandom_range(0, 1));
            m1_we_i  = 1'($urandom_range(0, 1));
            m0_adr_i = 5'($urandom);
            m1_adr_i = 5'($urandom);
            m0_dat_i = $urandom;
            m1_dat_i = $urandom;
            m0_sel_i = 4'($urandom);
            m1_sel_i = 4'($urandom);
            s_ack_i  = 1'($urandom_range(0, 1));
            s_dat_i  = $urandom;
            check_all("rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
